// File: rtl/gpr_pkg.sv
// Shared types and constants for the scoreboarded general-purpose register file.
package gpr_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/gpr_file_sb_if.sv
// Decode-stage bus of the register file: read ports, write ports, reserve handshake, flush.
interface gpr_file_sb_if
  import gpr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ready;
  logic                     flush;
  logic                     wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_pending, rsv_ready, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_pending, rsv_ready, wr_conflict
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: reserve/flush/write-complete update and read-side stall masking.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  input  logic                          flush,
  input  logic [2**ADDR_W-1:0]          wr_hit,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]             rd_pending,
  output logic                          rsv_ready
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_pending;
  logic             w_rsv_nonzero;
  logic             w_rsv_accept;

  assign w_rsv_nonzero = (rsv_addr != ADDR_W'(ZERO_REG));
  // A write landing this cycle retires the old producer, so a new one may claim the register.
  assign rsv_ready     = !w_rsv_nonzero || !r_pending[rsv_addr] || wr_hit[rsv_addr];
  assign w_rsv_accept  = rsv_en && rsv_ready && w_rsv_nonzero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending[0] <= 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
        if (w_rsv_accept && (rsv_addr == ADDR_W'(r))) r_pending[r] <= 1'b1;
        else if (flush)                               r_pending[r] <= 1'b0;
        else if (wr_hit[r])                           r_pending[r] <= 1'b0;
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_pending[i] = r_pending[rd_addr[i]] && !wr_hit[rd_addr[i]];
    end
  end

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port register file with write bypass, write-collision flag and pending scoreboard.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          reset,
  gpr_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]             r_regs [DEPTH];
  logic                          r_wr_conflict;

  logic [NUM_RD-1:0][ADDR_W-1:0] w_rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;
  logic [NUM_WR-1:0][ADDR_W-1:0] w_wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] w_wr_data;
  logic [NUM_WR-1:0]             w_wr_eff;
  logic [DEPTH-1:0]              w_wr_hit;
  logic                          w_conflict;

  assign w_rd_addr = bus.rd_addr;
  assign w_wr_addr = bus.wr_addr;
  assign w_wr_data = bus.wr_data;

  // Gating with reset keeps a write in flight during reset out of both the array and the bypass.
  always_comb begin
    w_wr_eff = '0;
    w_wr_hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_wr_eff[j] = reset && bus.wr_en[j] && (w_wr_addr[j] != ADDR_W'(ZERO_REG));
      if (w_wr_eff[j]) w_wr_hit[w_wr_addr[j]] = 1'b1;
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (w_wr_eff[i] && w_wr_eff[j] && (w_wr_addr[i] == w_wr_addr[j])) w_conflict = 1'b1;
      end
    end
  end

  // NOTE: the array is reset because reset must zero every architectural register; this
  // forces flops rather than RAM, which is acceptable at this depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment; on a shared address the
      // later (higher-index) port's assignment is the one that lands.
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_wr_eff[j]) r_regs[w_wr_addr[j]] <= w_wr_data[j];
      end
      r_wr_conflict <= w_conflict;
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_data[i] = r_regs[w_rd_addr[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_wr_eff[j] && (w_wr_addr[j] == w_rd_addr[i])) w_rd_data[i] = w_wr_data[j];
        end
      end
      if (w_rd_addr[i] == ADDR_W'(ZERO_REG)) w_rd_data[i] = '0;
    end
  end

  assign bus.rd_data     = w_rd_data;
  assign bus.wr_conflict = r_wr_conflict;

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .rsv_en     (bus.rsv_en),
    .rsv_addr   (bus.rsv_addr),
    .flush      (bus.flush),
    .wr_hit     (w_wr_hit),
    .rd_addr    (w_rd_addr),
    .rd_pending (bus.rd_pending),
    .rsv_ready  (bus.rsv_ready)
  );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed self-checking bench for gpr_file_sb with default parameters (BYPASS=1).
module tb_gpr_file_sb;
  import gpr_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  gpr_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(3), .NUM_WR(2)) bus ();

  gpr_file_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (3),
    .NUM_WR (2),
    .BYPASS (1)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic set_wr(input int j, input logic en, input reg_addr_t a, input reg_data_t d);
    bus.wr_en[j]           = en;
    bus.wr_addr[j*AW +: AW] = a;
    bus.wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input reg_addr_t a);
    bus.rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_rsv(input logic en, input reg_addr_t a);
    bus.rsv_en   = en;
    bus.rsv_addr = a;
  endtask

  function automatic reg_data_t rdd(input int i);
    return bus.rd_data[i*DW +: DW];
  endfunction

  task automatic test_reset();
    n_checks++; if (rdd(0) !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want %h", rdd(0), 32'h0); end
    n_checks++; if (bus.rd_pending !== 3'b000) begin n_fail++; $display("FAIL reset_pending: got %b want %b", bus.rd_pending, 3'b000); end
    n_checks++; if (bus.wr_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want %b", bus.wr_conflict, 1'b0); end
    set_rd(0, 5);
    rst_n = 1'b1;
    tick();
    set_wr(0, 1'b1, 5, 32'h5555_5555);
    set_rsv(1'b1, 5);
    tick();
    idle();
    settle();
    n_checks++; if (rdd(0) !== 32'h5555_5555) begin n_fail++; $display("FAIL pre_reset_data: got %h want %h", rdd(0), 32'h5555_5555); end
    n_checks++; if (bus.rd_pending[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pending: got %b want %b", bus.rd_pending[0], 1'b1); end
    set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
    settle();
    n_checks++; if (rdd(0) !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_pre_reset: got %h want %h", rdd(0), 32'hDEAD_BEEF); end
    rst_n = 1'b0;
    settle();
    n_checks++; if (rdd(0) !== 32'h0) begin n_fail++; $display("FAIL midwrite_reset_data: got %h want %h", rdd(0), 32'h0); end
    n_checks++; if (bus.rd_pending !== 3'b000) begin n_fail++; $display("FAIL midwrite_reset_pending: got %b want %b", bus.rd_pending, 3'b000); end
    tick();
    n_checks++; if (rdd(0) !== 32'h0) begin n_fail++; $display("FAIL reset_held_data: got %h want %h", rdd(0), 32'h0); end
    idle();
    rst_n = 1'b1;
    tick();
    n_checks++; if (rdd(0) !== 32'h0) begin n_fail++; $display("FAIL post_reset_data: got %h want %h", rdd(0), 32'h0); end
    n_checks++; if (bus.rd_pending !== 3'b000) begin n_fail++; $display("FAIL post_reset_pending: got %b want %b", bus.rd_pending, 3'b000); end
  endtask

  task automatic test_conflict();
    set_rd(0, 3);
    set_wr(0, 1'b1, 3, 32'h11);
    set_wr(1, 1'b1, 3, 32'h22);
    settle();
    n_checks++; if (rdd(0) !== 32'h22) begin n_fail++; $display("FAIL conflict_bypass: got %h want %h", rdd(0), 32'h22); end
    tick();
    idle();
    settle();
    n_checks++; if (rdd(0) !== 32'h22) begin n_fail++; $display("FAIL conflict_array: got %h want %h", rdd(0), 32'h22); end
    n_checks++; if (bus.wr_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_flag_set: got %b want %b", bus.wr_conflict, 1'b1); end
    tick();
    n_checks++; if (bus.wr_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_flag_clear: got %b want %b", bus.wr_conflict, 1'b0); end
    set_rd(1, 10);
    set_rd(2, 11);
    set_wr(0, 1'b1, 10, 32'hA0A0_0001);
    set_wr(1, 1'b1, 11, 32'hB0B0_0002);
    settle();
    n_checks++; if (rdd(1) !== 32'hA0A0_0001) begin n_fail++; $display("FAIL bypass_port0: got %h want %h", rdd(1), 32'hA0A0_0001); end
    tick();
    idle();
    settle();
    n_checks++; if (rdd(1) !== 32'hA0A0_0001) begin n_fail++; $display("FAIL distinct_wr0: got %h want %h", rdd(1), 32'hA0A0_0001); end
    n_checks++; if (rdd(2) !== 32'hB0B0_0002) begin n_fail++; $display("FAIL distinct_wr1: got %h want %h", rdd(2), 32'hB0B0_0002); end
    n_checks++; if (bus.wr_conflict !== 1'b0) begin n_fail++; $display("FAIL distinct_no_conflict: got %b want %b", bus.wr_conflict, 1'b0); end
  endtask

  task automatic test_reserve();
    set_rd(1, 7);
    set_rsv(1'b1, 7);
    settle();
    n_checks++; if (bus.rsv_ready !== 1'b1) begin n_fail++; $display("FAIL rsv_ready_free: got %b want %b", bus.rsv_ready, 1'b1); end
    tick();
    bus.rsv_en = 1'b0;
    settle();
    n_checks++; if (bus.rd_pending[1] !== 1'b1) begin n_fail++; $display("FAIL rsv_pending_set: got %b want %b", bus.rd_pending[1], 1'b1); end
    n_checks++; if (bus.rsv_ready !== 1'b0) begin n_fail++; $display("FAIL rsv_ready_busy: got %b want %b", bus.rsv_ready, 1'b0); end
    set_wr(0, 1'b1, 7, 32'hABCD);
    settle();
    n_checks++; if (bus.rd_pending[1] !== 1'b0) begin n_fail++; $display("FAIL wr_masks_pending: got %b want %b", bus.rd_pending[1], 1'b0); end
    n_checks++; if (rdd(1) !== 32'hABCD) begin n_fail++; $display("FAIL wr_bypass_7: got %h want %h", rdd(1), 32'hABCD); end
    n_checks++; if (bus.rsv_ready !== 1'b1) begin n_fail++; $display("FAIL rsv_ready_on_wr: got %b want %b", bus.rsv_ready, 1'b1); end
    tick();
    idle();
    settle();
    n_checks++; if (bus.rd_pending[1] !== 1'b0) begin n_fail++; $display("FAIL pending_cleared: got %b want %b", bus.rd_pending[1], 1'b0); end
  endtask

  task automatic test_write_and_reserve();
    set_rd(1, 7);
    set_rsv(1'b1, 7);
    tick();
    settle();
    n_checks++; if (bus.rsv_ready !== 1'b0) begin n_fail++; $display("FAIL rsv_hold_not_ready: got %b want %b", bus.rsv_ready, 1'b0); end
    tick();
    n_checks++; if (bus.rd_pending[1] !== 1'b1) begin n_fail++; $display("FAIL rsv_hold_pending: got %b want %b", bus.rd_pending[1], 1'b1); end
    set_wr(1, 1'b1, 7, 32'h1234);
    settle();
    n_checks++; if (bus.rsv_ready !== 1'b1) begin n_fail++; $display("FAIL wr_rsv_ready: got %b want %b", bus.rsv_ready, 1'b1); end
    tick();
    idle();
    settle();
    n_checks++; if (rdd(1) !== 32'h1234) begin n_fail++; $display("FAIL wr_rsv_data: got %h want %h", rdd(1), 32'h1234); end
    n_checks++; if (bus.rd_pending[1] !== 1'b1) begin n_fail++; $display("FAIL wr_rsv_pending: got %b want %b", bus.rd_pending[1], 1'b1); end
    set_wr(0, 1'b1, 7, 32'h1234);
    tick();
    idle();
    settle();
    n_checks++; if (bus.rd_pending[1] !== 1'b0) begin n_fail++; $display("FAIL wr_rsv_release: got %b want %b", bus.rd_pending[1], 1'b0); end
  endtask

  task automatic test_flush();
    set_rd(0, 4);
    set_rd(1, 9);
    set_rd(2, 12);
    set_rsv(1'b1, 4);
    tick();
    set_rsv(1'b1, 9);
    tick();
    set_rsv(1'b1, 12);
    tick();
    idle();
    settle();
    n_checks++; if (bus.rd_pending !== 3'b111) begin n_fail++; $display("FAIL three_pending: got %b want %b", bus.rd_pending, 3'b111); end
    bus.flush = 1'b1;
    tick();
    idle();
    settle();
    n_checks++; if (bus.rd_pending !== 3'b000) begin n_fail++; $display("FAIL flush_all: got %b want %b", bus.rd_pending, 3'b000); end
    bus.flush = 1'b1;
    set_rsv(1'b1, 9);
    tick();
    idle();
    settle();
    n_checks++; if (bus.rd_pending !== 3'b010) begin n_fail++; $display("FAIL flush_rsv: got %b want %b", bus.rd_pending, 3'b010); end
    set_rsv(1'b0, 9);
    set_rd(0, 3);
    settle();
    n_checks++; if (bus.rsv_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rsv_busy: got %b want %b", bus.rsv_ready, 1'b0); end
    n_checks++; if (rdd(0) !== 32'h22) begin n_fail++; $display("FAIL flush_keeps_data: got %h want %h", rdd(0), 32'h22); end
    set_wr(0, 1'b1, 9, 32'h9);
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    set_rd(0, 0);
    set_wr(0, 1'b1, 0, 32'hFFFF);
    set_wr(1, 1'b1, 0, 32'h1234);
    set_rsv(1'b1, 0);
    settle();
    n_checks++; if (rdd(0) !== 32'h0) begin n_fail++; $display("FAIL zero_bypass: got %h want %h", rdd(0), 32'h0); end
    n_checks++; if (bus.rsv_ready !== 1'b1) begin n_fail++; $display("FAIL zero_rsv_ready: got %b want %b", bus.rsv_ready, 1'b1); end
    n_checks++; if (bus.rd_pending[0] !== 1'b0) begin n_fail++; $display("FAIL zero_pending_now: got %b want %b", bus.rd_pending[0], 1'b0); end
    tick();
    idle();
    settle();
    n_checks++; if (rdd(0) !== 32'h0) begin n_fail++; $display("FAIL zero_array: got %h want %h", rdd(0), 32'h0); end
    n_checks++; if (bus.rd_pending[0] !== 1'b0) begin n_fail++; $display("FAIL zero_pending_next: got %b want %b", bus.rd_pending[0], 1'b0); end
    n_checks++; if (bus.wr_conflict !== 1'b0) begin n_fail++; $display("FAIL zero_no_conflict: got %b want %b", bus.wr_conflict, 1'b0); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.rd_addr = '0;
    idle();
    #12;
    test_reset();
    test_conflict();
    test_reserve();
    test_write_and_reserve();
    test_flush();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised successor to the single-write general register file, for the pipelined core's decode stage.
- Provides NUM_RD read ports and NUM_WR write ports.
- Bypasses same-cycle writes to readers.
- Keeps a per-register pending scoreboard so decode can stall on in-flight producers, including multi-cycle mult/div results.
- Register 0 is hardwired zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 3, number of read ports (>=1).
- NUM_WR, 2, number of write ports (>=1); a higher index has higher priority.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads see array contents only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_pending  out  NUM_RD  the addressed register awaits a producer (combinational).
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- rsv_en  in  1  reserve request: an issuing instruction will write rsv_addr.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ready  out  1  the reservation is accepted this cycle.
- flush  in  1  synchronous clear of all pending bits (pipeline flush).
- wr_conflict  out  1  registered flag: two or more write ports targeted the same nonzero address last cycle.

Behaviour:
- Reset (reset=0, async):
  - All registers = 0, all pending bits = 0, wr_conflict = 0.
  - Takes effect immediately mid-operation. Writes, reserves and flush are ignored while reset is low.
- Write:
  - Port j is effective when wr_en[j]=1 and wr_addr[j]!=0.
  - On posedge, reg[wr_addr[j]] <= wr_data[j].
  - If several effective ports share an address, the highest index wins, and wr_conflict is 1 for the next cycle only.
  - Writes to address 0 are discarded.
- Read (combinational):
  - rd_addr[i]==0 -> data 0.
  - Otherwise, if BYPASS=1 and an effective write port matches, data = wr_data of the highest matching port.
  - Otherwise data = reg[rd_addr[i]].
- Pending scoreboard, one bit per register; bit 0 is constant 0:
  - rd_pending[i] = pending[rd_addr[i]] AND NOT (an effective write matches rd_addr[i] this cycle). A completing write clears the stall combinationally, regardless of BYPASS.
- Reserve handshake:
  - rsv_ready = rsv_addr==0 OR !pending[rsv_addr] OR an effective write to rsv_addr this cycle.
  - Accepted when rsv_en && rsv_ready; pending[rsv_addr] is then 1 after posedge.
  - When not accepted, the requester holds rsv_en/rsv_addr stable and retries. The block holds no request state.
  - Reserve of address 0 is ready and ignored.
- Pending update priority per bit, highest first:
  1. reset.
  2. Accepted reserve to this address -> 1.
  3. flush -> 0.
  4. Effective write to this address -> 0.
  5. Hold.
- Simultaneous events:
  - Write and accepted reserve to the same register in one cycle: data is written and the bit is set, so the new producer owns it.
  - flush + accepted reserve: all bits clear except the newly reserved one.
  - flush does not alter register contents.
- Latency:
  - Write data is visible in the array one cycle after the write, and same-cycle via bypass.
  - Pending set is visible the cycle after acceptance.
- Widths: no arithmetic. All address compares are full ADDR_W.

Decomposition:
- Package gpr_pkg:
  - Default DATA_W/ADDR_W constants.
  - Typedefs reg_addr_t and reg_data_t.
  - Constant ZERO_REG = 0.
- Sub-module gpr_scoreboard owns:
  - The 2**ADDR_W pending vector.
  - rsv_ready.
  - The priority update.
  - rd_pending masking, fed with a one-hot "effective write" vector from the parent.
- The parent holds the data array, write arbitration, bypass muxes and wr_conflict.

Test Plan:
1. Reset low mid-write (wr_en[0]=1, addr 5, data 0xDEADBEEF) -> reg5 reads 0 and all rd_pending = 0 immediately; after release, reg5 still reads 0.
2. Same cycle: wr_en[0] to addr 3 with 0x11, wr_en[1] to addr 3 with 0x22, and rd_addr[0]=3 -> rd_data 0x22 with BYPASS=1. Next cycle reg3=0x22 and wr_conflict=1; the cycle after, wr_conflict=0.
3. Reserve addr 7 (accepted) -> next cycle rd_pending for 7 = 1 and rsv_ready for 7 = 0. Write 0xABCD to 7 -> same cycle rd_pending=0 and rd_data=0xABCD; the following cycle pending clears.
4. Pending 7, rsv_en to 7 together with a write to 7 -> rsv_ready=1, reg7 updated, pending stays 1.
5. Reserve 4, 9, 12, then flush alone -> all pending 0. Next: flush together with reserve of 9 -> only pending[9]=1.
6. Write 0xFFFF to addr 0 and reserve 0 -> rd_data for addr 0 = 0, rd_pending 0, rsv_ready 1, wr_conflict never set by addr-0 collisions.
